// File: rtl/alu_4bit_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_4bit_if
//  Purpose  : Operand/result bundle between a controller and alu_4bit.
//             The controller (master) drives the operands, opcode and valid
//             strobe. The ALU (slave) returns the registered result, the
//             flags and the result-valid strobe.
//  Signals  : in_valid  - operands/opcode valid this cycle   (master -> slave)
//             a, b      - 4-bit unsigned operands            (master -> slave)
//             opcode    - 3-bit operation select             (master -> slave)
//             x         - registered 4-bit result            (slave -> master)
//             carry     - carry / borrow / shift-out flag    (slave -> master)
//             zero      - 1 when x == 0                      (slave -> master)
//             out_valid - x/carry/zero are fresh this cycle  (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface alu_4bit_if;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] opcode;
    logic [3:0] x;
    logic       carry;
    logic       zero;
    logic       out_valid;

    modport master (
        output in_valid, a, b, opcode,
        input  x, carry, zero, out_valid
    );

    modport slave (
        input  in_valid, a, b, opcode,
        output x, carry, zero, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/alu_4bit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_4bit
//  Purpose  : Registered 4-bit ALU. A valid operand/opcode set is turned into
//             a 4-bit result plus carry and zero flags one clock later.
//             Without a valid input the result and flags hold their values.
//  Ports    : clk   - rising-edge clock
//             rst_n - asynchronous active-low reset
//             bus   - alu_4bit_if.slave (in_valid, a, b, opcode in;
//                     x, carry, zero, out_valid out)
//  Revision : 1.0  initial release
// ============================================================================
module alu_4bit (
    input  wire logic  clk,
    input  wire logic  rst_n,
    alu_4bit_if.slave  bus
);

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_AND  = 3'b010;
    localparam logic [2:0] c_OP_OR   = 3'b011;
    localparam logic [2:0] c_OP_XOR  = 3'b100;
    localparam logic [2:0] c_OP_NAND = 3'b101;
    localparam logic [2:0] c_OP_SHL  = 3'b110;
    localparam logic [2:0] c_OP_SHR  = 3'b111;

    logic [3:0] w_result;
    logic       w_carry;
    logic [4:0] w_sum;
    logic [4:0] w_diff;

    logic [3:0] r_x;
    logic       r_carry;
    logic       r_zero;
    logic       r_out_valid;

    // Both arithmetic paths are 5 bits wide so the top bit is the carry out
    // (ADD) or the borrow (SUB: wraps to 1 exactly when a < b).
    assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};

    always_comb begin
        w_result = 4'b0000;
        w_carry  = 1'b0;
        case (bus.opcode)
            c_OP_ADD: begin
                w_result = w_sum[3:0];
                w_carry  = w_sum[4];
            end
            c_OP_SUB: begin
                w_result = w_diff[3:0];
                w_carry  = w_diff[4];
            end
            c_OP_AND:  w_result = bus.a & bus.b;
            c_OP_OR:   w_result = bus.a | bus.b;
            c_OP_XOR:  w_result = bus.a ^ bus.b;
            c_OP_NAND: w_result = ~(bus.a & bus.b);
            c_OP_SHL: begin
                w_result = {bus.a[2:0], 1'b0};
                w_carry  = bus.a[3];
            end
            c_OP_SHR: begin
                w_result = {1'b0, bus.a[3:1]};
                w_carry  = bus.a[0];
            end
            default: begin
                w_result = 4'b0000;
                w_carry  = 1'b0;
            end
        endcase
    end

    // zero is derived from the new result, not from r_x, so it lands in the
    // same cycle as the result it describes. Reset sets zero to match x = 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x         <= 4'b0000;
            r_carry     <= 1'b0;
            r_zero      <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_x     <= w_result;
                r_carry <= w_carry;
                r_zero  <= (w_result == 4'b0000);
            end
        end
    end

    assign bus.x         = r_x;
    assign bus.carry     = r_carry;
    assign bus.zero      = r_zero;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_4bit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_4bit
//  Purpose  : Self-checking bench for alu_4bit. Directed vectors, reset
//             behaviour, handshake behaviour, an exhaustive opcode/operand
//             sweep and a randomized phase, all against an arithmetic model.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_4bit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_4bit_if bus ();

    alu_4bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Expected output state
    logic [3:0] exp_x = 4'd0;
    logic       exp_c = 1'b0;
    logic       exp_z = 1'b1;
    logic       exp_v = 1'b0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model using plain integer arithmetic; returns {carry, result}.
    function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
        int ai;
        int bi;
        int r;
        int c;
        logic [4:0] res;
        ai = int'(a);
        bi = int'(b);
        r  = 0;
        c  = 0;
        case (op)
            3'd0: begin r = (ai + bi) % 16;      c = ((ai + bi) > 15) ? 1 : 0; end
            3'd1: begin r = (ai - bi + 16) % 16; c = (ai < bi) ? 1 : 0;        end
            3'd2: r = int'(a & b);
            3'd3: r = int'(a | b);
            3'd4: r = int'(a ^ b);
            3'd5: r = 15 - int'(a & b);
            3'd6: begin r = (ai * 2) % 16;       c = ai / 8;                   end
            default: begin r = ai / 2;           c = ai % 2;                   end
        endcase
        res[3:0] = r[3:0];
        res[4]   = c[0];
        return res;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".x"},         {4'd0, bus.x},         {4'd0, exp_x});
        check({tag, ".carry"},     {7'd0, bus.carry},     {7'd0, exp_c});
        check({tag, ".zero"},      {7'd0, bus.zero},      {7'd0, exp_z});
        check({tag, ".out_valid"}, {7'd0, bus.out_valid}, {7'd0, exp_v});
    endtask

    // Present one cycle of stimulus at the falling edge, check after the
    // following rising edge.
    task automatic step(input string tag, input logic v, input logic [3:0] a,
                        input logic [3:0] b, input logic [2:0] op);
        logic [4:0] res;
        @(negedge clk);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.opcode   = op;
        @(posedge clk);
        #1;
        if (v) begin
            res   = ref_alu(a, b, op);
            exp_x = res[3:0];
            exp_c = res[4];
            exp_z = (res[3:0] == 4'd0);
        end
        exp_v = v;
        check_outputs(tag);
    endtask

    // Directly checks a directed vector's documented result, independent of
    // the model, so a model error cannot mask an RTL error.
    task automatic check_known(input string tag, input logic [3:0] x,
                               input logic c, input logic z);
        check({tag, ".known_x"}, {4'd0, bus.x},     {4'd0, x});
        check({tag, ".known_c"}, {7'd0, bus.carry}, {7'd0, c});
        check({tag, ".known_z"}, {7'd0, bus.zero},  {7'd0, z});
    endtask

    task automatic reset_model();
        exp_x = 4'd0;
        exp_c = 1'b0;
        exp_z = 1'b1;
        exp_v = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.a        = 4'd0;
        bus.b        = 4'd0;
        bus.opcode   = 3'd0;

        // Reset held low
        repeat (3) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        // Logic ops
        step("xor", 1'b1, 4'b0101, 4'b0011, 3'b100);  check_known("xor",  4'b0110, 1'b0, 1'b0);
        step("or",  1'b1, 4'b1010, 4'b0110, 3'b011);  check_known("or",   4'b1110, 1'b0, 1'b0);
        step("nand",1'b1, 4'b0011, 4'b0111, 3'b101);  check_known("nand", 4'b1100, 1'b0, 1'b0);
        step("and", 1'b1, 4'b1100, 4'b1010, 3'b010);  check_known("and",  4'b1000, 1'b0, 1'b0);

        // Arithmetic
        step("sub_borrow", 1'b1, 4'b0010, 4'b0011, 3'b001); check_known("sub_borrow", 4'b1111, 1'b1, 1'b0);
        step("add_wrap",   1'b1, 4'b1001, 4'b0111, 3'b000); check_known("add_wrap",   4'b0000, 1'b1, 1'b1);
        step("sub_equal",  1'b1, 4'b0101, 4'b0101, 3'b001); check_known("sub_equal",  4'b0000, 1'b0, 1'b1);

        // Shifts
        step("shr", 1'b1, 4'b1110, 4'b1011, 3'b111);  check_known("shr", 4'b0111, 1'b0, 1'b0);
        step("shl", 1'b1, 4'b1001, 4'b0000, 3'b110);  check_known("shl", 4'b0010, 1'b1, 1'b0);

        // Handshake: three back-to-back, then idle with changing operands
        step("b2b0", 1'b1, 4'd3, 4'd4, 3'd0);
        step("b2b1", 1'b1, 4'd9, 4'd2, 3'd1);
        step("b2b2", 1'b1, 4'd6, 4'd5, 3'd4);
        step("idle0", 1'b0, 4'd15, 4'd1, 3'd0);
        step("idle1", 1'b0, 4'd2,  4'd9, 3'd6);
        check_known("idle_hold", 4'd3, 1'b0, 1'b0);

        // Inputs changing between edges have no effect
        step("mid_pre", 1'b1, 4'd7, 4'd1, 3'd3);
        bus.a = 4'd0; bus.b = 4'd0; bus.opcode = 3'd2;
        #2;
        check_outputs("mid_change");

        // Asynchronous reset mid-stream with an in-flight valid input
        step("pre_rst", 1'b1, 4'b0101, 4'b0011, 3'b100);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.a = 4'd8; bus.b = 4'd3; bus.opcode = 3'd0;
        #2;
        rst_n = 1'b0;
        #1;
        reset_model();
        check_outputs("async_rst");
        @(posedge clk); #1;
        check_outputs("rst_held");
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_outputs("after_rst");
        step("first_after_rst", 1'b1, 4'd4, 4'd4, 3'd0);

        // Exhaustive sweep, back-to-back
        for (int op = 0; op < 8; op++) begin
            for (int ab = 0; ab < 256; ab++) begin
                step($sformatf("sweep_op%0d_a%0d_b%0d", op, ab / 16, ab % 16), 1'b1,
                     4'(ab / 16), 4'(ab % 16), 3'(op));
            end
        end

        // Randomized phase with random valid strobes
        for (int i = 0; i < 400; i++) begin
            step($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #500000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
